// File: rtl/dac_spi_sequencer_if.sv
// AXI4-Lite bundle for the gradient DAC sequencer.
// The sequencer is the slave side; the CPU side is the master.
interface dac_spi_sequencer_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport slave (
    input  awaddr, awprot, awvalid,
    input  wdata, wstrb, wvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    input  rready,
    output awready, wready,
    output bresp, bvalid,
    output arready,
    output rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid,
    output wdata, wstrb, wvalid,
    output bready,
    output araddr, arprot, arvalid,
    output rready,
    input  awready, wready,
    input  bresp, bvalid,
    input  arready,
    input  rdata, rresp, rvalid
  );
endinterface

// File: rtl/dac_spi_sequencer.sv
// Gradient DAC sequencer: three BRAM words per frame,
// shifted out on three SPI lines sharing clk/sync/ldac.
module dac_spi_sequencer #(
  parameter int    C_S_AXI_DATA_WIDTH = 32,
  parameter int    C_S_AXI_ADDR_WIDTH = 16,
  parameter int    BRAM_DATA_WIDTH    = 32,
  parameter int    BRAM_ADDR_WIDTH    = 14,
  parameter string CONTINUOUS         = "FALSE"
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [BRAM_ADDR_WIDTH-1:0] cfg_data,
  input  logic [BRAM_ADDR_WIDTH-1:0] current_offset,
  output logic [BRAM_ADDR_WIDTH-1:0] sts_data,
  output logic                       bram_portx_clk,
  output logic                       bram_portx_rst,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_portx_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_portx_rddata,
  output logic                       bram_porty_clk,
  output logic                       bram_porty_rst,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_porty_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_porty_rddata,
  output logic                       bram_portz_clk,
  output logic                       bram_portz_rst,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_portz_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_portz_rddata,
  output logic                       spi_clk,
  output logic                       spi_sdox,
  output logic                       spi_sdoy,
  output logic                       spi_sdoz,
  output logic                       spi_syncn,
  output logic                       spi_ldacn,
  output logic                       spi_clrn,
  dac_spi_sequencer_if.slave         s_axi
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LOAD
  } state_t;

  localparam int          AW        = BRAM_ADDR_WIDTH;
  localparam int          DW        = C_S_AXI_DATA_WIDTH;
  localparam bit          L_CONT    = (CONTINUOUS == "TRUE");
  localparam logic [15:0] L_PER_RST = 16'd1250;
  localparam logic [15:0] L_PER_MIN = 16'd104;
  localparam logic [15:0] L_CNT_RST = 16'd1243;

  state_t        r_state, w_state;
  logic [1:0]    r_phase, w_phase;
  logic [4:0]    r_bit, w_bit;
  logic [1:0]    r_ld, w_ld;
  logic [23:0]   r_shx, r_shy, r_shz;
  logic [23:0]   w_shx, w_shy, w_shz;
  logic [AW-1:0] r_addr, w_addr;
  logic          r_sclk, w_sclk;
  logic          r_sync, w_sync;
  logic          r_ldac, w_ldac;
  logic          r_sdx, r_sdy, r_sdz;
  logic          w_sdx, w_sdy, w_sdz;
  logic          r_clrn;

  logic [15:0]   r_cnt, r_per, r_per_act, w_per_eff;
  logic          w_start;

  logic          r_awready, r_bvalid;
  logic          r_arready, r_rvalid;
  logic [DW-1:0] r_rdata, w_rd;
  logic          w_aw_go, w_ar_go;
  logic          w_unused;

  assign w_per_eff = (r_per_act < L_PER_MIN) ? L_PER_MIN : r_per_act;
  assign w_start   = (r_state == S_IDLE) && (r_cnt == 16'd0);

  // Period counter; a new PERIOD is adopted only at the wrap
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_cnt     <= L_CNT_RST;
      r_per_act <= L_PER_RST;
    end else if (r_cnt >= w_per_eff - 16'd1) begin
      r_cnt     <= 16'd0;
      r_per_act <= r_per;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Frame FSM next state, shifters, address and SPI pin levels
  always_comb begin
    w_state = r_state;
    w_phase = r_phase;
    w_bit   = r_bit;
    w_ld    = r_ld;
    w_shx   = r_shx;
    w_shy   = r_shy;
    w_shz   = r_shz;
    w_addr  = r_addr;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state = S_SHIFT;
          w_phase = 2'd0;
          w_bit   = 5'd0;
          w_shx   = bram_portx_rddata[23:0];
          w_shy   = bram_porty_rddata[23:0];
          w_shz   = bram_portz_rddata[23:0];
        end
      end
      S_SHIFT: begin
        w_phase = r_phase + 2'd1;
        if (r_phase == 2'd3) begin
          w_shx = {r_shx[22:0], 1'b0};
          w_shy = {r_shy[22:0], 1'b0};
          w_shz = {r_shz[22:0], 1'b0};
          w_bit = r_bit + 5'd1;
          if (r_bit == 5'd23) begin
            w_state = S_LOAD;
            w_ld    = 2'd0;
          end
        end
      end
      S_LOAD: begin
        w_ld = r_ld + 2'd1;
        if (r_ld == 2'd3) begin
          w_state = S_IDLE;
          if (r_addr != cfg_data) begin
            w_addr = r_addr + AW'(1);
          end else if (L_CONT) begin
            w_addr = current_offset;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
    w_sync = (w_state != S_SHIFT);
    w_sclk = !((w_state == S_SHIFT) && w_phase[1]);
    w_sdx  = (w_state == S_SHIFT) && w_shx[23];
    w_sdy  = (w_state == S_SHIFT) && w_shy[23];
    w_sdz  = (w_state == S_SHIFT) && w_shz[23];
    w_ldac = (w_state != S_LOAD);
  end

  // State register with registered (glitch-free) SPI pins
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= S_IDLE;
      r_phase <= 2'd0;
      r_bit   <= 5'd0;
      r_ld    <= 2'd0;
      r_shx   <= '0;
      r_shy   <= '0;
      r_shz   <= '0;
      r_addr  <= current_offset;
      r_sclk  <= 1'b1;
      r_sync  <= 1'b1;
      r_ldac  <= 1'b1;
      r_sdx   <= 1'b0;
      r_sdy   <= 1'b0;
      r_sdz   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_phase <= w_phase;
      r_bit   <= w_bit;
      r_ld    <= w_ld;
      r_shx   <= w_shx;
      r_shy   <= w_shy;
      r_shz   <= w_shz;
      r_addr  <= w_addr;
      r_sclk  <= w_sclk;
      r_sync  <= w_sync;
      r_ldac  <= w_ldac;
      r_sdx   <= w_sdx;
      r_sdy   <= w_sdy;
      r_sdz   <= w_sdz;
    end
  end

  // DAC clear follows reset, released one cycle later
  always_ff @(posedge aclk) begin
    if (areset) r_clrn <= 1'b0;
    else        r_clrn <= 1'b1;
  end

  assign w_aw_go = s_axi.awvalid && s_axi.wvalid &&
                   !r_bvalid && !r_awready;
  assign w_ar_go = s_axi.arvalid && !r_rvalid && !r_arready;

  // AXI write channel: single PERIOD register, byte strobes 0/1
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_per     <= L_PER_RST;
    end else begin
      r_awready <= w_aw_go;
      if (r_awready && s_axi.awvalid && s_axi.wvalid) begin
        r_bvalid <= 1'b1;
        if (s_axi.awaddr[3:2] == 2'd0) begin
          if (s_axi.wstrb[0]) r_per[7:0]  <= s_axi.wdata[7:0];
          if (s_axi.wstrb[1]) r_per[15:8] <= s_axi.wdata[15:8];
        end
      end else if (r_bvalid && s_axi.bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Read data mux over the three status words
  always_comb begin
    w_rd = '0;
    unique case (s_axi.araddr[3:2])
      2'd0:    w_rd = DW'(r_per);
      2'd1:    w_rd = DW'(r_addr);
      2'd2:    w_rd = (DW'(cfg_data) << 16) | DW'(current_offset);
      default: w_rd = '0;
    endcase
  end

  // AXI read channel: data captured on the address handshake
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= w_ar_go;
      if (r_arready && s_axi.arvalid) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd;
      end else if (r_rvalid && s_axi.rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_awready;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.arready = r_arready;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = 2'b00;
  assign s_axi.rvalid  = r_rvalid;

  assign sts_data        = r_addr;
  assign bram_portx_clk  = aclk;
  assign bram_porty_clk  = aclk;
  assign bram_portz_clk  = aclk;
  assign bram_portx_rst  = areset;
  assign bram_porty_rst  = areset;
  assign bram_portz_rst  = areset;
  assign bram_portx_addr = r_addr;
  assign bram_porty_addr = r_addr;
  assign bram_portz_addr = r_addr;

  assign spi_clk   = r_sclk;
  assign spi_sdox  = r_sdx;
  assign spi_sdoy  = r_sdy;
  assign spi_sdoz  = r_sdz;
  assign spi_syncn = r_sync;
  assign spi_ldacn = r_ldac;
  assign spi_clrn  = r_clrn;

  assign w_unused = ^{s_axi.awprot, s_axi.arprot,
                      s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:4],
                      s_axi.awaddr[1:0],
                      s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:4],
                      s_axi.araddr[1:0],
                      s_axi.wdata[DW-1:16],
                      s_axi.wstrb[DW/8-1:2],
                      bram_portx_rddata[BRAM_DATA_WIDTH-1:24],
                      bram_porty_rddata[BRAM_DATA_WIDTH-1:24],
                      bram_portz_rddata[BRAM_DATA_WIDTH-1:24]};
endmodule

// File: tb/tb_dac_spi_sequencer.sv
// Bench for dac_spi_sequencer: SPI frame scoreboard,
// frame timing, address walk, AXI access and reset abort.
module tb_dac_spi_sequencer;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [13:0] cfg_data, current_offset;
  logic [31:0] rdx, rdy, rdz;

  logic [13:0] sts_f, ax, ay, az;
  logic        cx, cy, cz, rx, ry, rz;
  logic        sclk, sdx, sdy, sdz, syncn, ldacn, clrn;

  logic [13:0] sts_t, tax, tay, taz;
  logic        tcx, tcy, tcz, trx, try_, trz;
  logic        tsclk, tsdx, tsdy, tsdz, tsyncn, tldacn, tclrn;

  dac_spi_sequencer_if #(.AW(16), .DW(32)) axi ();
  dac_spi_sequencer_if #(.AW(16), .DW(32)) axi_t ();

  dac_spi_sequencer #(.CONTINUOUS("FALSE")) dut (
    .aclk(aclk), .areset(areset),
    .cfg_data(cfg_data), .current_offset(current_offset),
    .sts_data(sts_f),
    .bram_portx_clk(cx), .bram_portx_rst(rx),
    .bram_portx_addr(ax), .bram_portx_rddata(rdx),
    .bram_porty_clk(cy), .bram_porty_rst(ry),
    .bram_porty_addr(ay), .bram_porty_rddata(rdy),
    .bram_portz_clk(cz), .bram_portz_rst(rz),
    .bram_portz_addr(az), .bram_portz_rddata(rdz),
    .spi_clk(sclk), .spi_sdox(sdx), .spi_sdoy(sdy),
    .spi_sdoz(sdz), .spi_syncn(syncn), .spi_ldacn(ldacn),
    .spi_clrn(clrn), .s_axi(axi)
  );

  dac_spi_sequencer #(.CONTINUOUS("TRUE")) dut_c (
    .aclk(aclk), .areset(areset),
    .cfg_data(cfg_data), .current_offset(current_offset),
    .sts_data(sts_t),
    .bram_portx_clk(tcx), .bram_portx_rst(trx),
    .bram_portx_addr(tax), .bram_portx_rddata(rdx),
    .bram_porty_clk(tcy), .bram_porty_rst(try_),
    .bram_porty_addr(tay), .bram_porty_rddata(rdy),
    .bram_portz_clk(tcz), .bram_portz_rst(trz),
    .bram_portz_addr(taz), .bram_portz_rddata(rdz),
    .spi_clk(tsclk), .spi_sdox(tsdx), .spi_sdoy(tsdy),
    .spi_sdoz(tsdz), .spi_syncn(tsyncn), .spi_ldacn(tldacn),
    .spi_clrn(tclrn), .s_axi(axi_t)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [71:0] sbq[$];
  logic [71:0] m_e;
  int          n_start = 0;
  int          n_end = 0;
  int          t_start = 0;
  int          t_prev = 0;
  logic [13:0] st_f, st_t;
  int          bits = 0;
  int          lcnt = 0;
  logic [23:0] cap_x, cap_y, cap_z, last_z;
  logic        p_sync = 1'b1;
  logic        p_sclk = 1'b1;
  logic        p_ldac = 1'b1;

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  initial begin
    cap_x = '0; cap_y = '0; cap_z = '0; last_z = '0;
    forever begin
      @(negedge aclk);
      if (p_sync && !syncn) begin
        t_prev = t_start;
        t_start = cyc;
        st_f = sts_f;
        st_t = sts_t;
        bits = 0;
        n_start++;
      end
      if (!syncn && p_sclk && !sclk) begin
        cap_x = {cap_x[22:0], sdx};
        cap_y = {cap_y[22:0], sdy};
        cap_z = {cap_z[22:0], sdz};
        bits++;
      end
      if (!p_sync && syncn) begin
        if (areset) begin
          if (sbq.size() > 0) m_e = sbq.pop_front();
        end else begin
          chk("nbits", 32'(bits), 32'd24);
          chk("ldac_at_sync", 32'(ldacn), 32'd0);
          if (sbq.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
          end else begin
            m_e = sbq.pop_front();
            chk("sdo_x", 32'(cap_x), 32'(m_e[71:48]));
            chk("sdo_y", 32'(cap_y), 32'(m_e[47:24]));
            chk("sdo_z", 32'(cap_z), 32'(m_e[23:0]));
            last_z = cap_z;
          end
        end
        n_end++;
      end
      if (!ldacn) begin
        lcnt++;
      end else begin
        if (!p_ldac && !areset) chk("ldac_len", 32'(lcnt), 32'd4);
        lcnt = 0;
      end
      p_sync = syncn;
      p_sclk = sclk;
      p_ldac = ldacn;
    end
  end

  task automatic play(input logic [23:0] x,
                      input logic [23:0] y,
                      input logic [23:0] z);
    rdx = {8'hA5, x};
    rdy = {8'h5A, y};
    rdz = {8'hC3, z};
    sbq.push_back({x, y, z});
  endtask

  task automatic wait_start(input string tag);
    int n0 = n_start;
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge aclk); #1;
      if (n_start != n0) begin ok = 1'b1; break; end
    end
    if (!ok) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_end(input string tag);
    int n0 = n_end;
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge aclk); #1;
      if (n_end != n0) begin ok = 1'b1; break; end
    end
    if (!ok) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic axi_write(input logic [15:0] a,
                           input logic [31:0] d,
                           input logic [3:0]  s,
                           output logic [1:0] resp);
    bit ok = 1'b0;
    axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (axi.awready && axi.wready) begin ok = 1'b1; break; end
    end
    @(posedge aclk); #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    if (!ok) chk("aw_tmo", 32'd0, 32'd1);
    ok = 1'b0;
    resp = 2'b11;
    for (int i = 0; i < 50; i++) begin
      if (axi.bvalid) begin ok = 1'b1; resp = axi.bresp; break; end
      @(negedge aclk);
    end
    @(posedge aclk); #1;
    axi.bready = 1'b0;
    if (!ok) chk("b_tmo", 32'd0, 32'd1);
  endtask

  task automatic axi_read(input logic [15:0] a,
                          output logic [31:0] d,
                          output logic [1:0] resp);
    bit ok = 1'b0;
    axi.araddr = a; axi.arvalid = 1'b1; axi.rready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (axi.arready) begin ok = 1'b1; break; end
    end
    @(posedge aclk); #1;
    axi.arvalid = 1'b0;
    if (!ok) chk("ar_tmo", 32'd0, 32'd1);
    ok = 1'b0;
    d = 32'hDEAD_BEEF;
    resp = 2'b11;
    for (int i = 0; i < 50; i++) begin
      if (axi.rvalid) begin
        ok = 1'b1; d = axi.rdata; resp = axi.rresp; break;
      end
      @(negedge aclk);
    end
    @(posedge aclk); #1;
    axi.rready = 1'b0;
    if (!ok) chk("r_tmo", 32'd0, 32'd1);
  endtask

  int          exp_f[5] = '{5, 6, 7, 7, 7};
  int          exp_t[5] = '{5, 6, 7, 5, 6};
  int          t_rel;
  logic [31:0] d;
  logic [1:0]  resp;

  initial begin
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.araddr = '0; axi.arprot = '0;
    axi.arvalid = 1'b0; axi.rready = 1'b0;
    axi_t.awaddr = '0; axi_t.awprot = '0; axi_t.awvalid = 1'b0;
    axi_t.wdata = '0; axi_t.wstrb = '0; axi_t.wvalid = 1'b0;
    axi_t.bready = 1'b0; axi_t.araddr = '0; axi_t.arprot = '0;
    axi_t.arvalid = 1'b0; axi_t.rready = 1'b0;
    cfg_data = 14'd7;
    current_offset = 14'd5;
    areset = 1'b1;
    play(24'h123456, 24'h789ABC, 24'hDEF012);

    repeat (3) @(posedge aclk);
    #1;
    chk("rst_sync", 32'(syncn), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd1);
    chk("rst_ldac", 32'(ldacn), 32'd1);
    chk("rst_clrn", 32'(clrn), 32'd0);
    chk("rst_sdo", 32'({sdx, sdy, sdz}), 32'd0);
    chk("rst_sts", 32'(sts_f), 32'd5);
    chk("rst_addr", 32'({ax, ay, az}), 32'({14'd5, 14'd5, 14'd5}));
    chk("rst_axi_hs", 32'({axi.awready, axi.wready, axi.bvalid,
                          axi.arready, axi.rvalid}), 32'd0);
    chk("rst_resp", 32'({axi.bresp, axi.rresp}), 32'd0);

    @(posedge aclk); #1;
    areset = 1'b0;
    t_rel = cyc;
    wait_start("tmo_s0");
    chk("first_start", 32'(t_start - t_rel), 32'd8);
    chk("clrn_run", 32'(clrn), 32'd1);
    chk("sts_f0", 32'(st_f), 32'(exp_f[0]));
    chk("sts_t0", 32'(st_t), 32'(exp_t[0]));
    wait_end("tmo_e0");

    play(24'h966996, 24'h822882, 24'hDEADBE);
    wait_start("tmo_s1");
    chk("period_rst", 32'(t_start - t_prev), 32'd1250);
    chk("sts_f1", 32'(st_f), 32'(exp_f[1]));
    chk("sts_t1", 32'(st_t), 32'(exp_t[1]));
    wait_end("tmo_e1");
    chk("z_ne_deadb0", 32'(last_z != 24'hDEADB0), 32'd1);

    for (int k = 2; k < 5; k++) begin
      play(24'($urandom), 24'($urandom), 24'($urandom));
      wait_start("tmo_sk");
      chk("sts_fk", 32'(st_f), 32'(exp_f[k]));
      chk("sts_tk", 32'(st_t), 32'(exp_t[k]));
      wait_end("tmo_ek");
    end

    axi_write(16'h0000, 32'd200, 4'hF, resp);
    chk("bresp", 32'(resp), 32'd0);
    axi_read(16'h0000, d, resp);
    chk("rd_period", d, 32'd200);
    chk("rresp", 32'(resp), 32'd0);

    play(24'($urandom), 24'($urandom), 24'($urandom));
    wait_start("tmo_sa");
    wait_end("tmo_ea");
    play(24'($urandom), 24'($urandom), 24'($urandom));
    wait_start("tmo_sb");
    chk("period_200", 32'(t_start - t_prev), 32'd200);
    axi_read(16'h0004, d, resp);
    chk("rd_sts", d, 32'd7);
    axi_read(16'h0008, d, resp);
    chk("rd_cfg", d, 32'h0007_0005);
    axi_read(16'h000C, d, resp);
    chk("rd_0c", d, 32'd0);
    axi_write(16'h0000, 32'h0000_FF32, 4'b0001, resp);
    axi_read(16'h0000, d, resp);
    chk("rd_strb", d, 32'h0000_0032);
    wait_end("tmo_eb");

    play(24'($urandom), 24'($urandom), 24'($urandom));
    wait_start("tmo_sc");
    wait_end("tmo_ec");
    play(24'($urandom), 24'($urandom), 24'($urandom));
    wait_start("tmo_sd");
    chk("period_min", 32'(t_start - t_prev), 32'd104);
    wait_end("tmo_ed");

    play(24'($urandom), 24'($urandom), 24'($urandom));
    wait_start("tmo_se");
    repeat (20) @(posedge aclk);
    #1;
    areset = 1'b1;
    @(posedge aclk); #1;
    chk("abort_sync", 32'(syncn), 32'd1);
    chk("abort_sclk", 32'(sclk), 32'd1);
    chk("abort_clrn", 32'(clrn), 32'd0);
    repeat (2) @(posedge aclk);
    #1;
    chk("abort_sts", 32'(sts_f), 32'd5);

    play(24'hABCDEF, 24'h13579B, 24'h2468AC);
    @(posedge aclk); #1;
    areset = 1'b0;
    t_rel = cyc;
    wait_start("tmo_sf");
    chk("restart", 32'(t_start - t_rel), 32'd8);
    chk("restart_sts", 32'(st_f), 32'd5);
    wait_end("tmo_ef");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/dac_spi_sequencer.md
Name: dac_spi_sequencer

Overview:
Gradient DAC sequencer. It reads one 32-bit word per channel (x, y, z) from three BRAM ports and serialises the low 24 bits of each word simultaneously over three SPI data lines. The three lines share one SPI clock, sync and LDAC. Frames repeat at a programmable update period while the BRAM address walks from current_offset towards cfg_data. It sits between the per-channel gradient BRAMs and the external DAC chips, with an AXI4-Lite slave for configuration and status.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 16, AXI address width
BRAM_DATA_WIDTH, 32, BRAM word width; bits [23:0] are transmitted
BRAM_ADDR_WIDTH, 14, BRAM address width
CONTINUOUS, "FALSE", "TRUE" wraps the address to current_offset after cfg_data; "FALSE" holds the address at cfg_data

Ports:
aclk  in  1  sole clock for all logic, AXI and BRAM
areset  in  1  synchronous active-high reset
cfg_data  in  BRAM_ADDR_WIDTH  last BRAM address of the sequence
current_offset  in  BRAM_ADDR_WIDTH  first BRAM address of the sequence
sts_data  out  BRAM_ADDR_WIDTH  BRAM address currently being played
bram_port{x,y,z}_clk  out  1  equals aclk
bram_port{x,y,z}_rst  out  1  equals areset
bram_port{x,y,z}_addr  out  BRAM_ADDR_WIDTH  read address, common to all three ports
bram_port{x,y,z}_rddata  in  BRAM_DATA_WIDTH  read data, 1-cycle latency
spi_clk  out  1  SPI clock, idle high
spi_sdox, spi_sdoy, spi_sdoz  out  1  serial data, MSB first
spi_syncn  out  1  frame enable, active low
spi_ldacn  out  1  DAC load strobe, active low
spi_clrn  out  1  DAC clear, active low
S_AXI_* (AW/W/B/AR/R channels, including PROT and WSTRB)  various  standard AXI4-Lite slave

Behaviour:
- Reset values:
  - spi_clk=1, spi_syncn=1, spi_ldacn=1, spi_clrn=0 while areset, then 1.
  - SDO lines 0.
  - Address register = current_offset; sts_data = current_offset.
  - PERIOD register = 1250.
  - All AXI READY/VALID outputs 0; BRESP=RRESP=0.
- Period counter: counts 0..PERIOD-1. A frame starts when the counter is 0. The first frame starts 8 cycles after areset deasserts.
- Data latch: at frame start, latch rddata[23:0] of all three ports into 24-bit shift registers. The BRAM address has already been stable for at least 2 cycles at this point.
- State machine:
  - IDLE: outputs at idle levels.
  - SHIFT: spi_syncn=0 for 24 bits. Each bit lasts 4 aclk cycles: the bit is driven at bit start, spi_clk is high for 2 cycles, then low for 2 cycles. The DAC samples on the falling edge, so each frame has exactly 24 falling edges.
  - LOAD: spi_syncn=1, spi_clk=1. spi_ldacn is held low for 4 cycles.
  - Return to IDLE. A full frame is 96 + 4 cycles.
- Address update: after LOAD, the address increments by one if address != cfg_data.
  - At address == cfg_data with CONTINUOUS="TRUE": address reloads to current_offset.
  - At address == cfg_data with CONTINUOUS="FALSE": address holds, and the same word is resent every period.
  - Addresses wrap modulo 2^BRAM_ADDR_WIDTH.
- sts_data always equals bram_port*_addr.
- Effective period is max(PERIOD, 104) cycles; a frame is never truncated.
- Reset mid-frame: immediately returns all outputs to their reset values and aborts the frame.
- AXI write:
  - AWREADY and WREADY pulse together for one cycle when AWVALID && WVALID && !BVALID.
  - BVALID is held until BREADY. BRESP is always OKAY.
  - Address 0x00 (bits [3:2]=0) writes PERIOD[15:0]; WSTRB bytes 0 and 1 are honoured.
  - All other addresses are ignored.
- AXI read:
  - ARREADY pulses for one cycle when ARVALID && !RVALID; RVALID is held until RREADY.
  - 0x00 returns PERIOD, zero-extended.
  - 0x04 returns sts_data, zero-extended.
  - 0x08 returns {cfg_data, current_offset} packed as cfg_data<<16 | current_offset.
  - Other addresses return 0.
- A PERIOD write takes effect at the next counter wrap.

Test Plan:
- Reset, then rddata x=0x123456, y=0x789ABC, z=0xDEF012 -> first frame: 24 falling spi_clk edges with syncn low; receivers capture 0x123456/0x789ABC/0xDEF012; ldacn low 4 cycles after syncn rises.
- Change rddata to 0x966996/0x822882/0xDEADBE -> next frame, 1250 cycles after the previous start, carries the new values. A checker expecting 0xDEADB0 on z must flag a mismatch.
- current_offset=5, cfg_data=7, CONTINUOUS="FALSE" -> sts_data sequence 5,6,7,7,7. With CONTINUOUS="TRUE" -> 5,6,7,5,6.
- AXI write 0x00=200, read 0x00 -> returns 200; frame starts are then spaced 200 cycles apart. Write 50 -> spacing is 104.
- AXI read 0x04 during playback -> matches sts_data. Read 0x0C -> 0. BRESP/RRESP = 0.
- areset asserted mid-SHIFT -> next cycle syncn=1, spi_clk=1, clrn=0; the sequence restarts at current_offset after release.
